// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller and its datapath.
package mc_defs;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd7
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_LUI  = 3'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] WTR_ALU  = 2'd0;
  localparam logic [1:0] WTR_MEM  = 2'd1;
  localparam logic [1:0] WTR_PC4  = 2'd2;

  // One-hot instruction class; all zero means the instruction is illegal.
  typedef struct packed {
    logic addu;
    logic subu;
    logic jr;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic j;
    logic jal;
  } instr_class_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bus between the multi-cycle sequencer and the MIPS datapath.
interface mc_ctrl_if #(parameter int CNT_W = 32);
  import mc_defs::*;

  logic [31:0]      instr;
  logic             eq;
  logic             im_ready;
  logic             dm_ready;
  logic             ir_we;
  logic             pc_we;
  logic             WeGrf;
  logic             WeDm;
  logic [1:0]       RegDst;
  logic [1:0]       WhichtoReg;
  logic             AluSrc;
  logic [2:0]       AluOp;
  logic             sign;
  logic             branch;
  logic             JType;
  logic             jr;
  logic [2:0]       state;
  logic             illegal;
  logic             halted;
  logic [CNT_W-1:0] retired;

  // Datapath side: supplies IR, flags and memory readiness, consumes controls.
  modport master (
    output instr, eq, im_ready, dm_ready,
    input  ir_we, pc_we, WeGrf, WeDm, RegDst, WhichtoReg, AluSrc, AluOp,
           sign, branch, JType, jr, state, illegal, halted, retired
  );

  // Sequencer side.
  modport slave (
    input  instr, eq, im_ready, dm_ready,
    output ir_we, pc_we, WeGrf, WeDm, RegDst, WhichtoReg, AluSrc, AluOp,
           sign, branch, JType, jr, state, illegal, halted, retired
  );

endinterface

// File: rtl/mc_ctrl_decode.sv
// Purely combinational instruction classifier for the sequencer.
module mc_decode
  import mc_defs::*;
(
  input  logic [31:0]  instr_i,
  output instr_class_t cls_o,
  output logic         illegal_o
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unusedFields;

  assign opcode       = instr_i[31:26];
  assign funct        = instr_i[5:0];
  assign unusedFields = ^instr_i[25:6];

  // Map opcode/funct onto exactly one class bit, or none for unknown encodings.
  always_comb begin
    cls_o = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls_o.addu = 1'b1;
          FN_SUBU: cls_o.subu = 1'b1;
          FN_JR:   cls_o.jr   = 1'b1;
          default: ;
        endcase
      end
      OP_ORI:  cls_o.ori = 1'b1;
      OP_LW:   cls_o.lw  = 1'b1;
      OP_SW:   cls_o.sw  = 1'b1;
      OP_BEQ:  cls_o.beq = 1'b1;
      OP_LUI:  cls_o.lui = 1'b1;
      OP_J:    cls_o.j   = 1'b1;
      OP_JAL:  cls_o.jal = 1'b1;
      default: ;
    endcase
  end

  assign illegal_o = (cls_o == '0);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle sequencer: steps the datapath through FETCH/DECODE/EXEC/MEM/WB,
// waits on memory ready handshakes, counts retired instructions and halts
// when a memory never answers.
module mc_ctrl
  import mc_defs::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input logic     clk,
  input logic     reset,
  mc_ctrl_if.slave bus
);

  localparam int              WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  waitCnt_q, waitCnt_d, waitInc;
  logic [CNT_W-1:0]   retired_q;

  instr_class_t       cls;
  logic               isIllegal;

  logic               irWe, pcWe, weGrf, weDm;
  logic [1:0]         regDst, whichtoReg;
  logic               aluSrc, signExt, branchSel, jType, jrSel, illegalPulse;
  logic [2:0]         aluOp;
  logic               aluSrcI, signI;
  logic [2:0]         aluOpI;

  mc_decode uDecode (
    .instr_i   (bus.instr),
    .cls_o     (cls),
    .illegal_o (isIllegal)
  );

  // ALU setup for the current instruction, used from EXEC through WB.
  always_comb begin
    aluSrcI = cls.ori | cls.lw | cls.sw | cls.lui;
    signI   = cls.lw | cls.sw;
    aluOpI  = ALU_ADD;
    if (cls.subu || cls.beq) aluOpI = ALU_SUB;
    else if (cls.ori)        aluOpI = ALU_OR;
    else if (cls.lui)        aluOpI = ALU_LUI;
  end

  assign waitInc = (waitCnt_q == WAIT_MAX) ? waitCnt_q : waitCnt_q + 1'b1;

  // Next-state and control decode; everything defaults to idle.
  always_comb begin
    state_d      = state_q;
    waitCnt_d    = '0;
    irWe         = 1'b0;
    pcWe         = 1'b0;
    weGrf        = 1'b0;
    weDm         = 1'b0;
    regDst       = REGDST_RT;
    whichtoReg   = WTR_ALU;
    aluSrc       = 1'b0;
    aluOp        = ALU_ADD;
    signExt      = 1'b0;
    branchSel    = 1'b0;
    jType        = 1'b0;
    jrSel        = 1'b0;
    illegalPulse = 1'b0;
    case (state_q)
      ST_FETCH: begin
        irWe = bus.im_ready;
        if (bus.im_ready)           state_d = ST_DECODE;
        else if (waitInc >= WAIT_MAX) state_d = ST_HALT;
        else                        waitCnt_d = waitInc;
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
        if (cls.j) begin
          pcWe = 1'b1; jType = 1'b1; state_d = ST_FETCH;
        end else if (cls.jal) begin
          pcWe = 1'b1; jType = 1'b1; weGrf = 1'b1;
          regDst = REGDST_RA; whichtoReg = WTR_PC4; state_d = ST_FETCH;
        end else if (cls.jr) begin
          pcWe = 1'b1; jrSel = 1'b1; state_d = ST_FETCH;
        end else if (isIllegal) begin
          pcWe = 1'b1; illegalPulse = 1'b1; state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        aluSrc = aluSrcI; aluOp = aluOpI; signExt = signI;
        if (cls.beq) begin
          pcWe = 1'b1; branchSel = bus.eq; state_d = ST_FETCH;
        end else if (cls.lw || cls.sw) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        aluSrc = aluSrcI; aluOp = aluOpI; signExt = signI;
        weDm   = cls.sw;
        if (bus.dm_ready) begin
          pcWe    = cls.sw;
          state_d = cls.sw ? ST_FETCH : ST_WB;
        end else if (waitInc >= WAIT_MAX) begin
          state_d = ST_HALT;
        end else begin
          waitCnt_d = waitInc;
        end
      end
      ST_WB: begin
        aluSrc = aluSrcI; aluOp = aluOpI; signExt = signI;
        weGrf      = 1'b1;
        pcWe       = 1'b1;
        regDst     = (cls.addu || cls.subu) ? REGDST_RD : REGDST_RT;
        whichtoReg = cls.lw ? WTR_MEM : WTR_ALU;
        state_d    = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // State, wait counter and retire counter; reset abandons any instruction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      waitCnt_q <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      if (pcWe) retired_q <= retired_q + 1'b1;
    end
  end

  assign bus.ir_we      = reset & irWe;
  assign bus.pc_we      = reset & pcWe;
  assign bus.WeGrf      = reset & weGrf;
  assign bus.WeDm       = reset & weDm;
  assign bus.illegal    = reset & illegalPulse;
  assign bus.RegDst     = regDst;
  assign bus.WhichtoReg = whichtoReg;
  assign bus.AluSrc     = aluSrc;
  assign bus.AluOp      = aluOp;
  assign bus.sign       = signExt;
  assign bus.branch     = branchSel;
  assign bus.JType      = jType;
  assign bus.jr         = jrSel;
  assign bus.state      = state_q;
  assign bus.halted     = (state_q == ST_HALT);
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: builds the expected cycle-by-cycle trace of
// each instruction from the instruction's class and handshake delays, then
// drives the DUT with that trace and compares every cycle.
module tb_mc_ctrl;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 16;

  typedef enum int {K_ADDU, K_SUBU, K_JR, K_ORI, K_LW, K_SW, K_BEQ,
                    K_LUI, K_J, K_JAL, K_ILL} kind_e;

  typedef struct packed {
    logic       irWe, pcWe, weGrf, weDm;
    logic [1:0] regDst, wtr;
    logic       aluSrc;
    logic [2:0] aluOp;
    logic       sgn, br, jt, jrs, ill, hlt;
  } ctl_t;

  typedef struct {
    logic [31:0] instr;
    logic        im, dm, eqv;
    logic [2:0]  st;
    ctl_t        ctl;
  } cyc_t;

  logic clk = 1'b0;
  logic reset;
  cyc_t cycQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;
  logic [CNT_W-1:0] expRetired = '0;

  always #5 clk = ~clk;

  mc_ctrl_if #(.CNT_W(CNT_W)) bus ();

  mc_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Random encoding of an instruction of the given kind.
  function automatic logic [31:0] makeInstr(input kind_e k);
    logic [31:0] w;
    logic [5:0]  badOps [3];
    w = $urandom;
    badOps[0] = 6'b111111; badOps[1] = 6'b001000; badOps[2] = 6'b000101;
    case (k)
      K_ADDU: begin w[31:26] = 6'b000000; w[5:0] = 6'b100001; end
      K_SUBU: begin w[31:26] = 6'b000000; w[5:0] = 6'b100011; end
      K_JR:   begin w[31:26] = 6'b000000; w[5:0] = 6'b001000; end
      K_ORI:  w[31:26] = 6'b001101;
      K_LW:   w[31:26] = 6'b100011;
      K_SW:   w[31:26] = 6'b101011;
      K_BEQ:  w[31:26] = 6'b000100;
      K_LUI:  w[31:26] = 6'b001111;
      K_J:    w[31:26] = 6'b000010;
      K_JAL:  w[31:26] = 6'b000011;
      default: begin
        if (w[6]) begin w[31:26] = 6'b000000; w[5:0] = 6'b101010; end
        else      w[31:26] = badOps[$urandom_range(0, 2)];
      end
    endcase
    return w;
  endfunction

  task automatic pushCycle(input logic [31:0] ins, input logic im, input logic dm,
                           input logic eqv, input logic [2:0] st, input ctl_t c);
    cyc_t e;
    e.instr = ins; e.im = im; e.dm = dm; e.eqv = eqv; e.st = st; e.ctl = c;
    cycQ.push_back(e);
  endtask

  // Expected trace of one instruction. A delay of MEM_TIMEOUT or more means
  // the memory never answers, so the trace stops where HALT would begin.
  task automatic genInstr(input kind_e k, input int imDelay, input int dmDelay, input logic eqv);
    logic [31:0] ins;
    ctl_t c, a;
    ins = makeInstr(k);
    for (int i = 0; i < imDelay && i < MEM_TIMEOUT; i++) begin
      c = '0; pushCycle(ins, 1'b0, rnd(), rnd(), 3'd0, c);
    end
    if (imDelay >= MEM_TIMEOUT) return;
    c = '0; c.irWe = 1'b1; pushCycle(ins, 1'b1, rnd(), rnd(), 3'd0, c);
    c = '0;
    case (k)
      K_J:   begin c.pcWe = 1; c.jt = 1; end
      K_JAL: begin c.pcWe = 1; c.jt = 1; c.weGrf = 1; c.regDst = 2; c.wtr = 2; end
      K_JR:  begin c.pcWe = 1; c.jrs = 1; end
      K_ILL: begin c.pcWe = 1; c.ill = 1; end
      default: ;
    endcase
    pushCycle(ins, rnd(), rnd(), rnd(), 3'd1, c);
    if (c.pcWe) return;
    a = '0;
    a.aluSrc = (k == K_ORI || k == K_LW || k == K_SW || k == K_LUI);
    a.sgn    = (k == K_LW || k == K_SW);
    case (k)
      K_SUBU, K_BEQ: a.aluOp = 3'd1;
      K_ORI:         a.aluOp = 3'd2;
      K_LUI:         a.aluOp = 3'd3;
      default:       a.aluOp = 3'd0;
    endcase
    c = a;
    if (k == K_BEQ) begin
      c.pcWe = 1; c.br = eqv;
      pushCycle(ins, rnd(), rnd(), eqv, 3'd2, c);
      return;
    end
    pushCycle(ins, rnd(), rnd(), rnd(), 3'd2, c);
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i < dmDelay && i < MEM_TIMEOUT; i++) begin
        c = a; c.weDm = (k == K_SW);
        pushCycle(ins, rnd(), 1'b0, rnd(), 3'd3, c);
      end
      if (dmDelay >= MEM_TIMEOUT) return;
      c = a; c.weDm = (k == K_SW); c.pcWe = (k == K_SW);
      pushCycle(ins, rnd(), 1'b1, rnd(), 3'd3, c);
      if (k == K_SW) return;
    end
    c = '0; c.weGrf = 1; c.pcWe = 1;
    c.regDst = (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0;
    c.wtr    = (k == K_LW) ? 2'd1 : 2'd0;
    pushCycle(ins, rnd(), rnd(), rnd(), 3'd4, c);
  endtask

  task automatic genHalt(input int n);
    ctl_t c;
    for (int i = 0; i < n; i++) begin
      c = '0; c.hlt = 1'b1;
      pushCycle($urandom, rnd(), rnd(), rnd(), 3'd7, c);
    end
  endtask

  // Drive one cycle of the trace and compare mid-cycle.
  task automatic applyStimulus(input cyc_t e);
    ctl_t o;
    @(negedge clk);
    reset        = 1'b1;
    bus.instr    = e.instr;
    bus.im_ready = e.im;
    bus.dm_ready = e.dm;
    bus.eq       = e.eqv;
    #2;
    o = '0;
    o.irWe = bus.ir_we; o.pcWe = bus.pc_we; o.weGrf = bus.WeGrf; o.weDm = bus.WeDm;
    o.regDst = bus.RegDst; o.wtr = bus.WhichtoReg;
    if (e.st == 3'd2 || e.st == 3'd3) begin
      o.aluSrc = bus.AluSrc; o.aluOp = bus.AluOp; o.sgn = bus.sign;
    end
    o.br = bus.branch; o.jt = bus.JType; o.jrs = bus.jr;
    o.ill = bus.illegal; o.hlt = bus.halted;
    checkOutput("state", 32'(bus.state), 32'(e.st));
    checkOutput("ctl", 32'(o), 32'(e.ctl));
    checkOutput("retired", 32'(bus.retired), 32'(expRetired));
    @(posedge clk);
    if (e.ctl.pcWe) expRetired = expRetired + 1'b1;
  endtask

  task automatic runQueue();
    while (cycQ.size() > 0) applyStimulus(cycQ.pop_front());
  endtask

  // Hold reset low for n edges; enables must stay low meanwhile.
  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset        = 1'b0;
      bus.im_ready = 1'b1;
      bus.dm_ready = 1'b1;
      bus.eq       = rnd();
      #2;
      checkOutput("rstEnables",
                  {27'd0, bus.ir_we, bus.pc_we, bus.WeGrf, bus.WeDm, bus.illegal}, 32'd0);
      @(posedge clk);
    end
    expRetired = '0;
  endtask

  initial begin
    reset = 1'b0;
    bus.instr = '0; bus.im_ready = 1'b0; bus.dm_ready = 1'b0; bus.eq = 1'b0;
    doReset(2);

    genInstr(K_ADDU, 0, 0, 1'b0);
    genInstr(K_LW,   0, 2, 1'b0);
    genInstr(K_SW,   0, 1, 1'b0);
    genInstr(K_BEQ,  0, 0, 1'b1);
    genInstr(K_BEQ,  0, 0, 1'b0);
    genInstr(K_JAL,  0, 0, 1'b0);
    genInstr(K_ILL,  0, 0, 1'b0);
    runQueue();

    genInstr(K_ADDU, MEM_TIMEOUT, 0, 1'b0);
    genHalt(4);
    runQueue();
    doReset(1);

    genInstr(K_LW, 0, MEM_TIMEOUT, 1'b0);
    genHalt(3);
    runQueue();
    doReset(1);

    genInstr(K_SW, 1, 3, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(cycQ.pop_front());
    cycQ.delete();
    doReset(1);

    repeat (200) begin
      genInstr(kind_e'($urandom_range(0, 10)), $urandom_range(0, 3),
               $urandom_range(0, 3), rnd());
      runQueue();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not end, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle sequencer for the MIPS datapath. Replaces the single-cycle control decode.
- Per instruction, steps the datapath through FETCH/DECODE/EXEC/MEM/WB and drives its existing control inputs (WeGrf, WeDm, RegDst, WhichtoReg, AluSrc, AluOp, sign, branch, JType, jr) plus new PC and IR write enables.
- Waits on ready handshakes from IM and DM, counts retired instructions, and halts on a memory timeout.

Parameters:
- CNT_W, 32: width of the retire counter.
- MEM_TIMEOUT, 16: maximum cycles to wait for a ready in FETCH or MEM before HALT; must be ≥ 1.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low (reset==0 at a rising edge clears the block).
- instr  in  32  IR contents from the datapath; stable from DECODE until the instruction ends.
- eq  in  1  ALU equality flag, valid in EXEC.
- im_ready  in  1  IM has data valid this cycle.
- dm_ready  in  1  DM read data valid, or write accepted, this cycle.
- ir_we  out  1  load IR.
- pc_we  out  1  load PC from NPC.
- WeGrf  out  1  GRF write enable.
- WeDm  out  1  DM write enable.
- RegDst  out  2  0=rt, 1=rd, 2=$31.
- WhichtoReg  out  2  0=ALU, 1=Mem, 2=PC4.
- AluSrc  out  1  0=reg, 1=imm32.
- AluOp  out  3  0=ADD, 1=SUB, 2=OR, 3=LUI.
- sign  out  1  EXT sign-extend.
- branch  out  1  NPC selects branch target.
- JType  out  1  NPC selects jump target.
- jr  out  1  NPC selects register target.
- state  out  3  current state, for debug.
- illegal  out  1  1-cycle pulse on an undecodable instruction.
- halted  out  1  sticky HALT indicator.
- retired  out  CNT_W  instructions completed.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- Reset (reset==0 at a clock edge):
  - state=FETCH; wait counter=0; retired=0; illegal=0; halted=0.
  - All enables 0 while reset is low.
  - Reset mid-instruction abandons it; no write completes.
- Decode:
  - opcode=instr[31:26], funct=instr[5:0].
  - R-type (opcode 000000): funct 100001 addu, 100011 subu, 001000 jr.
  - I/J opcodes: ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010, jal 000011.
  - Any other opcode or funct is illegal.
- FETCH:
  - ir_we = im_ready.
  - On im_ready: go to DECODE, clear the wait counter.
  - Otherwise increment the wait counter; when it reaches MEM_TIMEOUT, go to HALT.
- DECODE:
  - j: pc_we=1, JType=1, go to FETCH.
  - jal: pc_we=1, JType=1, WeGrf=1, RegDst=2, WhichtoReg=2, go to FETCH. PC4 is still the old PC+4 at this point.
  - jr: pc_we=1, jr=1, go to FETCH.
  - illegal: pc_we=1 (sequential PC), illegal pulse, go to FETCH.
  - All other instructions: go to EXEC.
- EXEC:
  - AluSrc=1 for ori/lw/sw/lui; 0 otherwise.
  - sign=1 for lw/sw only.
  - AluOp: ADD for addu/lw/sw; SUB for subu/beq; OR for ori; LUI for lui.
  - beq: pc_we=1, branch=eq, go to FETCH.
  - lw/sw: go to MEM.
  - Others: go to WB.
- MEM (ALU controls held as in EXEC):
  - sw: WeDm=1 every cycle until dm_ready; on dm_ready, pc_we=1 and go to FETCH.
  - lw: on dm_ready, go to WB.
  - Timeout counting as in FETCH.
- WB:
  - WeGrf=1 and pc_we=1, then go to FETCH.
  - RegDst=1 for R-type, 0 otherwise.
  - WhichtoReg=1 for lw, 0 otherwise.
- Write-enable rules:
  - pc_we is high for exactly one cycle per instruction, in the instruction's final state.
  - WeGrf is high for at most one cycle per instruction.
- retired:
  - Increments in every cycle that pc_we=1, including illegal instructions.
  - Wraps modulo 2^CNT_W.
- HALT:
  - All enables 0, halted=1.
  - Only reset exits HALT.
- Ready timing:
  - If a ready input is high on the first cycle of FETCH or MEM, that state lasts 1 cycle.
  - The wait counter saturates and is cleared on every state change.
- Outputs are Moore-style, decoded from state and instr. The exceptions are ir_we, pc_we in MEM, and branch in EXEC, which are combinational from the ready/eq inputs.

Decomposition:
- Shared package mc_defs holds:
  - state encodings;
  - opcode and funct constants;
  - AluOp, RegDst and WhichtoReg encodings.
  The datapath muxes and ALU use the same constants.
- One sub-module, mc_decode: purely combinational, instr → instruction-class one-hot plus illegal.
- The FSM, wait counter and retire counter stay in mc_ctrl.

Test Plan:
- addu with im_ready=1 throughout → FETCH, DECODE, EXEC, WB (4 cycles); WeGrf=1 with RegDst=1 in WB only; retired goes 0→1.
- lw with dm_ready asserted on the 3rd MEM cycle → MEM lasts 3 cycles then WB with WhichtoReg=1; a following sw holds WeDm=1 for 2 cycles when dm_ready arrives on its 2nd MEM cycle.
- beq with eq=1 → pc_we=1 and branch=1 in EXEC, returns to FETCH, 3 cycles total. With eq=0 → branch=0, pc_we=1.
- jal → 2 cycles; in DECODE WeGrf=1, RegDst=2, WhichtoReg=2, JType=1, pc_we=1.
- Opcode 111111 → illegal pulses for 1 cycle, pc_we=1, retired increments; im_ready held 0 for 16 cycles → HALT, halted=1, all enables 0; reset=0 for 1 cycle → FETCH, retired=0.
- reset=0 asserted in MEM of an sw → no WeDm after the edge; state=FETCH next cycle.
